uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rr_pick.sv | 15 +
 rtl/uart_tx_arbiter.sv | 79 +++++++
 tb/tb_uart_tx_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state type for the UART transmit arbiter.
package uart_pkg;
    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick starting just after the last grant.
module uart_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_id,
    output logic       any
);
    always_comb begin
        gnt_id = '0;
        // scan farthest-first so the closest requester after last wins
        for (int k = 4; k >= 1; k--)
            if (req[last + 2'(k)]) gnt_id = last + 2'(k);
        any = |req;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter
// among four byte requesters, with a sticky flag for a transmitter that never goes busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = uart_pkg::NUM_REQ,
    parameter int BUSY_TIMEOUT = uart_pkg::BUSY_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    state_t        state, state_nx;
    logic [1:0]    pick, last_grant;
    logic          any, last_byte, accept, timed_out, done;
    logic [CW-1:0] cnt;

    uart_rr_pick u_pick (
        .req    (req_valid),
        .last   (last_grant),
        .gnt_id (pick),
        .any    (any)
    );

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = state == ISSUE && req_valid[grant_id] && !tx_busy;
        accept              = req_ready[grant_id];
        timed_out           = state == WAIT_BUSY && !tx_busy && cnt == CW'(BUSY_TIMEOUT - 1);
        // a timed-out byte finishes exactly like one whose frame ended
        done                = timed_out || (state == WAIT_DONE && !tx_busy);
        state_nx            = state == IDLE  ? (any ? ISSUE : IDLE) :
                              state == ISSUE ? (accept ? WAIT_BUSY : ISSUE) :
                              done           ? (last_byte ? IDLE : ISSUE) :
                              (state == WAIT_BUSY && tx_busy) ? WAIT_DONE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_active <= 1'b0;
            grant_id     <= '0;
            last_grant   <= 2'd3;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            last_byte    <= 1'b0;
            cnt          <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_start <= accept;
            cnt      <= (state == WAIT_BUSY && !tx_busy) ? cnt + 1'b1 : '0;
            if (state == IDLE && any) begin
                grant_active <= 1'b1;
                grant_id     <= pick;
            end
            if (accept) begin
                tx_data   <= req_data[8*grant_id +: 8];
                last_byte <= req_last[grant_id];
            end
            if (timed_out) err_timeout <= 1'b1;
            if (done && last_byte) begin
                grant_active <= 1'b0;
                last_grant   <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized packets from four requesters plus a reactive UART
// model, checked cycle by cycle against a phase/timestamp model of the arbiter.
module tb_uart_tx_arbiter;
    typedef enum {FREE, GRANTED, SENDING} phase_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_start, tx_busy, grant_active, err_timeout;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .err_timeout  (err_timeout)
    );

    logic [7:0] qb [4][64];
    bit         ql [4][64];
    int         head [4];
    int         tail [4];

    phase_t     phase = FREE;
    int         m_owner = 0, m_last = 3, t_start = 0, cyc = 0;
    bit         saw_busy, cur_last, pkt_started, chk_gid = 1;
    logic       exp_ts = 0, exp_ga = 0, exp_err = 0;
    logic [1:0] exp_gid = 0;
    logic [7:0] exp_txd = 0;
    int         busy_on = 0, busy_off = 0, to_until = 0, stall_left = 0;
    bit         force_to, long_pending = 1, rst_round, after_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return 0;
    endfunction

    function automatic bit drained();
        for (int i = 0; i < 4; i++)
            if (head[i] != tail[i]) return 0;
        return 1;
    endfunction

    task automatic build(input int r);
        logic [3:0] mask;
        int         np, len;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        mask      = (r == 1 || after_rst) ? 4'hf : 4'($urandom_range(1, 15));
        after_rst = 0;
        force_to  = r == 2;
        rst_round = r == 5 || r == 10;
        if (r == 0) begin
            qb[0][0] = 8'h73;
            ql[0][0] = 1;
            tail[0]  = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!mask[i]) continue;
                np = r == 1 ? 1 : $urandom_range(1, 3);
                for (int p = 0; p < np; p++) begin
                    len = r == 1 ? 1 : $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        qb[i][tail[i]] = 8'($urandom);
                        ql[i][tail[i]] = k == len - 1;
                        tail[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0]  v, l, exp_rdy;
        logic [31:0] d;
        logic        b;
        bit          stalled, acc, done, do_rst;
        check("tx_start", tx_start, exp_ts);
        check("tx_data", tx_data, exp_txd);
        check("err_timeout", err_timeout, exp_err);
        check("grant_active", grant_active, exp_ga);
        if (exp_ga || chk_gid) check("grant_id", grant_id, exp_gid);
        chk_gid = 0;
        // UART reaction: a frame some cycles after each start, or silence for a timeout
        if (exp_ts) begin
            if (force_to || $urandom_range(0, 7) == 0) begin
                to_until = cyc + 16;
                busy_on  = 0;
                busy_off = 0;
                force_to = 0;
            end else begin
                busy_on  = cyc + $urandom_range(0, 3);
                busy_off = busy_on + $urandom_range(1, 6);
            end
        end
        b = cyc < busy_off ? cyc >= busy_on : (cyc >= to_until && $urandom_range(0, 9) == 0);
        if (stall_left == 0 && phase == GRANTED && pkt_started) begin
            if (long_pending) begin
                stall_left   = 50;
                long_pending = 0;
            end else if ($urandom_range(0, 19) == 0)
                stall_left = $urandom_range(1, 6);
        end
        stalled = stall_left > 0;
        if (stalled) stall_left--;
        for (int i = 0; i < 4; i++) begin
            v[i]         = head[i] != tail[i] && !(stalled && i == m_owner);
            d[8*i +: 8]  = v[i] ? qb[i][head[i]] : 8'($urandom);
            l[i]         = v[i] ? ql[i][head[i]] : 1'($urandom);
        end
        do_rst    = rst_round && phase == SENDING && b && cyc > t_start + 1;
        rst       = do_rst;
        req_valid = do_rst ? 4'b0 : v;
        req_data  = d;
        req_last  = l;
        tx_busy   = b;
        #1;
        if (do_rst) begin
            for (int i = 0; i < 4; i++) head[i] = tail[i];
            phase = FREE;  m_last = 3;  exp_ts = 0;  exp_ga = 0;  exp_err = 0;
            exp_gid = 0;  exp_txd = 0;  chk_gid = 1;  stall_left = 0;
            busy_off = 0;  to_until = 0;  rst_round = 0;  after_rst = 1;
            cyc++;
            return;
        end
        exp_rdy = 0;
        if (phase == GRANTED && v[m_owner] && !b) exp_rdy[m_owner] = 1;
        check("req_ready", req_ready, exp_rdy);
        acc    = exp_rdy != 0;
        exp_ts = acc;
        case (phase)
            FREE: if (v != 0) begin
                m_owner     = rr(v, m_last);
                exp_gid     = 2'(m_owner);
                exp_ga      = 1;
                pkt_started = 0;
                phase       = GRANTED;
            end
            GRANTED: if (acc) begin
                exp_txd     = qb[m_owner][head[m_owner]];
                cur_last    = ql[m_owner][head[m_owner]];
                head[m_owner]++;
                pkt_started = 1;
                saw_busy    = 0;
                t_start     = cyc + 1;
                phase       = SENDING;
            end
            SENDING: begin
                done = 0;
                if (!saw_busy) begin
                    if (b) saw_busy = 1;
                    else if (cyc == t_start + 15) begin
                        done    = 1;
                        exp_err = 1;
                    end
                end else if (!b) done = 1;
                if (done && cur_last) begin
                    phase  = FREE;
                    m_last = m_owner;
                    exp_ga = 0;
                end else if (done) phase = GRANTED;
            end
        endcase
        cyc++;
    endtask

    initial begin
        int budget;
        rst       = 1;
        req_valid = 0;
        req_data  = 0;
        req_last  = 0;
        tx_busy   = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int r = 0; r < 14; r++) begin
            build(r);
            budget = 0;
            do begin
                @(negedge clk);
                step();
                budget++;
            end while (!(drained() && phase == FREE) && budget < 3000);
            check("round_drained", {30'b0, drained(), phase == FREE}, 32'd3);
        end
        repeat (4) begin
            @(negedge clk);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
